uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter, the TX half of the UART block. Accepts a parallel
//  byte with a valid strobe, then shifts out one frame on TX_OUT:
//  start(0), data LSB-first, optional parity, stop(1).
//  Each bit lasts PRESCALE cycles of CLK, so its timing matches the RX
//  oversampling factor on the same link.
// PARAMETERS
//  width   8   data bits per frame
// PORTS
//  CLK         in   1      system clock, single clock domain
//  RST         in   1      asynchronous reset, active-high
//  P_DATA      in   width  parallel data to send
//  DATA_VALID  in   1      request strobe; accepted only when BUSY==0
//  PAR_EN      in   1      1 = append parity bit
//  PAR_TYP     in   1      0 = even parity, 1 = odd parity
//  PRESCALE    in   6      CLK cycles per bit (legal 1..63; 0 is treated as 1)
//  TX_OUT      out  1      serial line, idles high
//  BUSY        out  1      high from acceptance through the last stop cycle
// BEHAVIOUR
//  - Reset (async, RST=1): TX_OUT=1, BUSY=0, FSM=IDLE, counters=0. Applies
//    immediately, including mid-frame; the frame in flight is abandoned.
//  - FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
//  - Acceptance: at edge k, FSM in IDLE with DATA_VALID=1 latches P_DATA,
//    PAR_EN, PAR_TYP and PRESCALE. From cycle k+1: TX_OUT=0, BUSY=1.
//    All outputs are registered.
//  - Config inputs changing mid-frame have no effect; latched copies are used.
//  - DATA_VALID while BUSY=1 is ignored. Requests are not queued.
//  - Bit timer counts 0..PRESCALE-1. Each bit holds TX_OUT for exactly
//    PRESCALE cycles. A bit index 0..width-1 selects the data bit.
//  - Parity is computed from the latched data:
//    even -> ^data; odd -> ~^data.
//  - Frame length is 1+width+PAR_EN+1 bits (10 or 11 for width=8).
//  - After the final stop cycle: FSM=IDLE, BUSY=0, TX_OUT=1. A new frame can be
//    accepted on the first IDLE edge, so at least one idle-high cycle separates
//    frames.
//  - DATA_VALID held high continuously: frames repeat, each separated by that
//    single idle cycle.
// CONFIGURATION
//  UART_TX_TWO_STOP_EN defined:
//    STOP state lasts 2 bit periods (2*PRESCALE cycles); frame is 11/12 bits.
//  Not defined:
//    one stop bit as above; no extra logic is synthesized.
// STRUCTURE
//  - Package uart_pkg holds:
//    - tx state encoding (IDLE, START, DATA, PARITY, STOP)
//    - PAR_EVEN/PAR_ODD constants
//    - the PRESCALE width constant (6)
//  - Sub-module uart_tx_bit_timer: PRESCALE down-counter with load/enable that
//    emits a one-cycle bit_done pulse.
//  - Top holds the FSM, shift register, bit index and parity register.
// TESTING
//  CLK is 200 MHz (5 ns period). Check TX_OUT at the mid-point of each bit.
//  1. PRESCALE=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xAA
//     -> TX_OUT = 0,0,1,0,1,0,1,0,1,0,1; each bit 8 cycles; BUSY high 88 cycles.
//  2. PRESCALE=16, PAR_EN=1, PAR_TYP=1, P_DATA=0xAA
//     -> parity bit=1; frame 0,0,1,0,1,0,1,0,1,1,1; BUSY high 176 cycles.
//  3. PRESCALE=32, PAR_EN=0, P_DATA=0xAA
//     -> 10-bit frame 0,0,1,0,1,0,1,0,1,1; BUSY high 320 cycles.
//  4. PRESCALE=8, PAR_EN=1, PAR_TYP=0, DATA_VALID held high, 0xAA then 0xEA
//     -> two frames, exactly 1 idle cycle between them; second parity=1.
//     Pulse DATA_VALID with 0x55 mid-frame -> ignored.
//  5. Assert RST during the DATA state -> TX_OUT=1 and BUSY=0 in the same cycle;
//     a subsequent 0x3C frame is sent correctly.
//  6. Loopback to UART_RX with matching PRESCALE and parity, all modes above
//     -> P_DATA matches, PAR_ERR=0, STP_ERR=0.
//     Rerun 1 with UART_TX_TWO_STOP_EN -> stop lasts 16 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the UART block.
//  - tx_state_t : transmitter FSM encoding (IDLE, START, DATA, PARITY, STOP)
//  - PAR_EVEN / PAR_ODD : values of the PAR_TYP select
//  - PRESCALE_W : width of the PRESCALE (CLK cycles per bit) field
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

  localparam int PRESCALE_W = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_tx_bit_timer
//  Bit-period timer for the UART transmitter. On load it captures PRESCALE
//  (0 is treated as 1) and starts a down-counter at PRESCALE-1. While enabled
//  the counter runs down and reloads itself; bit_done pulses for one cycle
//  on the last CLK cycle of every bit period.
// Ports
//  CLK       in   1           system clock
//  RST       in   1           asynchronous reset, active-high
//  load      in   1           capture prescale and restart the period
//  enable    in   1           count while a frame is in progress
//  prescale  in   PRESCALE_W  CLK cycles per bit
//  bit_done  out  1           last cycle of the current bit period
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] reload_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] reload_d;

  // A prescale of 0 behaves as 1: reload value 0 gives a one-cycle bit.
  assign reload_d = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);

  assign bit_done = enable && !load && (cnt_q == '0);

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      reload_q <= reload_d;
      cnt_q    <= reload_d;
    end else if (enable) begin
      cnt_q <= (cnt_q == '0) ? reload_q : cnt_q - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//  UART transmitter. Accepts a byte on DATA_VALID while idle and sends one
//  frame: start(0), data LSB-first, optional parity, stop(1). Every bit lasts
//  PRESCALE CLK cycles. All configuration is latched at acceptance.
//  Build option: define UART_TX_TWO_STOP_EN for a two-bit-period stop.
// Ports
//  CLK         in   1           system clock
//  RST         in   1           asynchronous reset, active-high
//  P_DATA      in   width       parallel data to send
//  DATA_VALID  in   1           request strobe, honoured only while idle
//  PAR_EN      in   1           1 = append parity bit
//  PAR_TYP     in   1           PAR_EVEN / PAR_ODD
//  PRESCALE    in   PRESCALE_W  CLK cycles per bit (0 acts as 1)
//  TX_OUT      out  1           serial line, idles high (registered)
//  BUSY        out  1           frame in progress (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx
  import uart_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [width-1:0]      P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int              IDX_W    = (width > 1) ? $clog2(width) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(width - 1);

  tx_state_t        state_q;
  logic [width-1:0] shift_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             accept;
  logic             bit_done;
`ifdef UART_TX_TWO_STOP_EN
  logic             stop_second_q;
`endif

  assign accept = (state_q == IDLE) && DATA_VALID;

  uart_tx_bit_timer u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .enable   (state_q != IDLE),
    .prescale (PRESCALE),
    .bit_done (bit_done)
  );

  // NOTE: the asynchronous reset forces the line high and drops BUSY at once,
  // abandoning any frame in flight without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      TX_OUT        <= 1'b1;
      BUSY          <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_second_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (DATA_VALID) begin
            state_q   <= START;
            shift_q   <= P_DATA;
            bit_idx_q <= '0;
            par_en_q  <= PAR_EN;
            par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
            TX_OUT    <= 1'b0;
            BUSY      <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            stop_second_q <= 1'b0;
`endif
          end
        end

        START: begin
          if (bit_done) begin
            state_q <= DATA;
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end

        // shift_q[0] always holds the next data bit to put on the line.
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
              if (par_en_q) begin
                state_q <= PARITY;
                TX_OUT  <= par_bit_q;
              end else begin
                state_q <= STOP;
                TX_OUT  <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              TX_OUT    <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end

        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            TX_OUT  <= 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
            if (!stop_second_q) begin
              stop_second_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              BUSY    <= 1'b0;
              TX_OUT  <= 1'b1;
            end
`else
            state_q <= IDLE;
            BUSY    <= 1'b0;
            TX_OUT  <= 1'b1;
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          BUSY    <= 1'b0;
          TX_OUT  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//  Self-checking bench for uart_tx. Expected line bits are pushed to a queue
//  when a frame is requested and popped as the frame appears on TX_OUT; each
//  bit is checked on its first, middle and last cycle, and the BUSY length is
//  compared against the frame length times the bit period.
//  Honours UART_TX_TWO_STOP_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx;
  import uart_pkg::*;

  localparam int WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic                  CLK_tb = 1'b0;
  logic                  RST_tb = 1'b1;
  logic [WIDTH-1:0]      P_DATA_tb = '0;
  logic                  DATA_VALID_tb = 1'b0;
  logic                  PAR_EN_tb = 1'b0;
  logic                  PAR_TYP_tb = 1'b0;
  logic [PRESCALE_W-1:0] PRESCALE_tb = '0;
  logic                  TX_OUT_tb;
  logic                  BUSY_tb;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  uart_tx #(.width(WIDTH)) dut (
    .CLK        (CLK_tb),
    .RST        (RST_tb),
    .P_DATA     (P_DATA_tb),
    .DATA_VALID (DATA_VALID_tb),
    .PAR_EN     (PAR_EN_tb),
    .PAR_TYP    (PAR_TYP_tb),
    .PRESCALE   (PRESCALE_tb),
    .TX_OUT     (TX_OUT_tb),
    .BUSY       (BUSY_tb)
  );

  always #2.5 CLK_tb = ~CLK_tb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  // Reference frame: start, data LSB-first, parity from a ones count, stop(s).
  task automatic push_frame(input logic [WIDTH-1:0] data, input logic par_en, input logic par_typ);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      exp_q.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (par_en) begin
      if (par_typ == PAR_ODD) exp_q.push_back((ones % 2) == 0);
      else                    exp_q.push_back((ones % 2) == 1);
    end
    for (int s = 0; s < STOP_BITS; s++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [WIDTH-1:0] data, input int p, input logic par_en, input logic par_typ);
    P_DATA_tb     = data;
    PRESCALE_tb   = PRESCALE_W'(p);
    PAR_EN_tb     = par_en;
    PAR_TYP_tb    = par_typ;
    DATA_VALID_tb = 1'b1;
    tick();
    DATA_VALID_tb = 1'b0;
  endtask

  // Called on the first cycle of a frame. inject_at >= 0 pulses a competing
  // request (with different config) at that cycle of the frame.
  task automatic monitor(input string tag, input int p, input int nbits, input int inject_at);
    int   c;
    logic cur;
    c   = 0;
    cur = 1'b1;
    while (BUSY_tb === 1'b1 && c < 8000) begin
      if (c % p == 0) begin
        check({tag, "_extra_bit"}, 32'(exp_q.size() != 0), 32'd1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
        check({tag, "_bit_first"}, 32'(TX_OUT_tb), 32'(cur));
      end
      if (c % p == p / 2) check({tag, "_bit_mid"}, 32'(TX_OUT_tb), 32'(cur));
      if (c % p == p - 1) check({tag, "_bit_last"}, 32'(TX_OUT_tb), 32'(cur));
      if (inject_at >= 0 && c == inject_at) begin
        P_DATA_tb     = 8'h55;
        PRESCALE_tb   = 6'd3;
        PAR_EN_tb     = 1'b0;
        PAR_TYP_tb    = PAR_ODD;
        DATA_VALID_tb = 1'b1;
      end
      if (inject_at >= 0 && c == inject_at + 1) DATA_VALID_tb = 1'b0;
      tick();
      c++;
    end
    check({tag, "_busy_cycles"}, 32'(c), 32'(p * nbits));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_tx_out", 32'(TX_OUT_tb), 32'd1);
    check("reset_busy", 32'(BUSY_tb), 32'd0);
    RST_tb = 1'b0;
    tick();

    // 1: even parity, 0xAA, 8 cycles/bit
    push_frame(8'hAA, 1'b1, PAR_EVEN);
    send(8'hAA, 8, 1'b1, PAR_EVEN);
    monitor("t1", 8, 10 + STOP_BITS, -1);
    tick();

    // 2: odd parity, 16 cycles/bit
    push_frame(8'hAA, 1'b1, PAR_ODD);
    send(8'hAA, 16, 1'b1, PAR_ODD);
    monitor("t2", 16, 10 + STOP_BITS, -1);
    tick();

    // 3: no parity, 32 cycles/bit
    push_frame(8'hAA, 1'b0, PAR_EVEN);
    send(8'hAA, 32, 1'b0, PAR_EVEN);
    monitor("t3", 32, 9 + STOP_BITS, -1);
    tick();

    // 4a: DATA_VALID held high, back-to-back frames 0xAA then 0xEA
    push_frame(8'hAA, 1'b1, PAR_EVEN);
    push_frame(8'hEA, 1'b1, PAR_EVEN);
    P_DATA_tb     = 8'hAA;
    PRESCALE_tb   = 6'd8;
    PAR_EN_tb     = 1'b1;
    PAR_TYP_tb    = PAR_EVEN;
    DATA_VALID_tb = 1'b1;
    tick();
    P_DATA_tb = 8'hEA;
    begin
      int c;
      logic first_frame[$];
      // Split the shared queue so the first frame is checked alone.
      for (int i = 0; i < 10 + STOP_BITS; i++) first_frame.push_back(exp_q.pop_front());
      c = 0;
      while (BUSY_tb === 1'b1 && c < 8000) begin
        if (c % 8 == 4) check("t4_frame1_bit_mid", 32'(TX_OUT_tb), 32'(first_frame[c / 8]));
        tick();
        c++;
      end
      check("t4_frame1_busy_cycles", 32'(c), 32'(8 * (10 + STOP_BITS)));
    end
    check("t4_gap_busy", 32'(BUSY_tb), 32'd0);
    check("t4_gap_tx_out", 32'(TX_OUT_tb), 32'd1);
    tick();
    check("t4_second_accept", 32'(BUSY_tb), 32'd1);
    DATA_VALID_tb = 1'b0;
    monitor("t4_frame2", 8, 10 + STOP_BITS, -1);

    // 4b: request pulsed mid-frame is ignored and not queued
    tick();
    push_frame(8'hAA, 1'b1, PAR_EVEN);
    send(8'hAA, 8, 1'b1, PAR_EVEN);
    monitor("t4_ignore", 8, 10 + STOP_BITS, 30);
    for (int i = 0; i < 5; i++) begin
      check("t4_ignore_idle_busy", 32'(BUSY_tb), 32'd0);
      check("t4_ignore_idle_tx", 32'(TX_OUT_tb), 32'd1);
      tick();
    end

    // 5: reset during DATA, then a clean 0x3C frame
    send(8'h00, 8, 1'b1, PAR_EVEN);
    repeat (8 + 8 * 2 + 3) tick();
    check("t5_in_data_tx", 32'(TX_OUT_tb), 32'd0);
    check("t5_in_data_busy", 32'(BUSY_tb), 32'd1);
    RST_tb = 1'b1;
    #1;
    check("t5_reset_tx_out", 32'(TX_OUT_tb), 32'd1);
    check("t5_reset_busy", 32'(BUSY_tb), 32'd0);
    tick();
    RST_tb = 1'b0;
    tick();
    check("t5_post_reset_busy", 32'(BUSY_tb), 32'd0);
    push_frame(8'h3C, 1'b1, PAR_ODD);
    send(8'h3C, 8, 1'b1, PAR_ODD);
    monitor("t5_frame", 8, 10 + STOP_BITS, -1);
    tick();

    // 6: PRESCALE=0 acts as 1 cycle per bit
    push_frame(8'h81, 1'b0, PAR_EVEN);
    send(8'h81, 0, 1'b0, PAR_EVEN);
    monitor("t6_presc0", 1, 9 + STOP_BITS, -1);
    tick();

    // 7: PRESCALE=63, odd parity
    push_frame(8'h5A, 1'b1, PAR_ODD);
    send(8'h5A, 63, 1'b1, PAR_ODD);
    monitor("t7_presc63", 63, 10 + STOP_BITS, -1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
